// File: rtl/smc_seq_ctrl.sv
// Serial device front-end and sequencer: evaluates ID/gm per beat, keeps a descending
// sorted buffer of N_DEV results, then returns the weighted sum of the top or bottom K.
module smc_seq_ctrl #(
  parameter int N_DEV = 6,
  parameter int K     = 3,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [2:0]       W,
  input  logic [2:0]       V_GS,
  input  logic [2:0]       V_DS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_n
);

  localparam int CW = $clog2(N_DEV + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SUM, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode;
  logic [OUT_W-1:0] r_buf [N_DEV];
  logic [OUT_W-1:0] r_out;

  logic             w_acc;
  logic [1:0]       w_mode_eff;
  logic             w_triode;
  logic [11:0]      w_w, w_gs, w_ds, w_gs_m1, w_num;
  logic [OUT_W-1:0] w_val;
  logic [N_DEV-1:0] w_ge;
  logic [OUT_W-1:0] w_ins [N_DEV];
  logic [OUT_W-1:0] w_sum;
  logic [OUT_W-1:0] w_wt;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign out_valid = (r_state == S_DONE);
  assign out_n     = r_out;
  assign w_acc     = in_valid && in_ready;

  // The first beat of a transaction evaluates with the live mode, later beats with the latched one.
  assign w_mode_eff = (r_state == S_IDLE) ? mode : r_mode;

  assign w_w     = {9'd0, W};
  assign w_gs    = {9'd0, V_GS};
  assign w_ds    = {9'd0, V_DS};
  assign w_gs_m1 = w_gs - 12'd1;
  assign w_triode = ({1'b0, V_GS}) > ({1'b0, V_DS} + 4'd1);

  always_comb begin
    w_num = 12'd0;
    if (V_GS != 3'd0) begin
      if (w_triode) begin
        if (w_mode_eff[0]) w_num = w_ds * w_w * ((w_gs << 1) - w_ds - 12'd2);
        else               w_num = (w_w * w_ds) << 1;
      end else begin
        if (w_mode_eff[0]) w_num = w_w * w_gs_m1 * w_gs_m1;
        else               w_num = (w_w * w_gs_m1) << 1;
      end
    end
  end

  assign w_val = OUT_W'(w_num / 12'd3);

  // Insert after all entries >= the new value, so ties land behind existing equals.
  always_comb begin
    for (int i = 0; i < N_DEV; i++) w_ge[i] = (r_buf[i] >= w_val);
    w_ins[0] = w_ge[0] ? r_buf[0] : w_val;
    for (int i = 1; i < N_DEV; i++) begin
      if (w_ge[i])        w_ins[i] = r_buf[i];
      else if (w_ge[i-1]) w_ins[i] = w_val;
      else                w_ins[i] = r_buf[i-1];
    end
  end

  always_comb begin
    w_sum = '0;
    w_wt  = '0;
    for (int j = 0; j < K; j++) begin
      w_wt  = r_mode[0] ? OUT_W'(3 + j) : OUT_W'(1);
      w_sum = w_sum + r_buf[r_mode[1] ? j : (N_DEV - K + j)] * w_wt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = (N_DEV == 1) ? S_SUM : S_LOAD;
      S_LOAD: if (w_acc && (r_cnt == CW'(N_DEV - 1))) w_state_nxt = S_SUM;
      S_SUM:  w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_out   <= '0;
      for (int i = 0; i < N_DEV; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        for (int i = 0; i < N_DEV; i++) r_buf[i] <= w_ins[i];
        if (r_state == S_IDLE) begin
          r_mode <= mode;
          r_cnt  <= CW'(1);
        end else begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end
      if (r_state == S_SUM) r_out <= w_sum;
      if ((r_state == S_DONE) && out_ready) begin
        r_cnt <= '0;
        for (int i = 0; i < N_DEV; i++) r_buf[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Directed plus randomized bench for smc_seq_ctrl against a sort-and-sum reference model.
module tb_smc_seq_ctrl;

  localparam int N_DEV = 6;
  localparam int K     = 3;
  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       mode = 2'b00;
  logic [2:0]       W = 3'd0;
  logic [2:0]       V_GS = 3'd0;
  logic [2:0]       V_DS = 3'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_n;

  int n_cmp = 0;
  int n_err = 0;

  int tw [N_DEV];
  int tg [N_DEV];
  int td [N_DEV];

  smc_seq_ctrl #(.N_DEV(N_DEV), .K(K), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .W(W), .V_GS(V_GS), .V_DS(V_DS),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_val(input int w, input int gs, input int ds, input bit is_id);
    if (gs == 0) return 0;
    if (gs > ds + 1) return is_id ? (ds * w * (2 * gs - ds - 2)) / 3 : (2 * w * ds) / 3;
    return is_id ? (w * (gs - 1) * (gs - 1)) / 3 : (2 * w * (gs - 1)) / 3;
  endfunction

  function automatic int ref_sum(input logic [1:0] m);
    int q[$];
    int s = 0;
    int base;
    for (int i = 0; i < N_DEV; i++) q.push_back(ref_val(tw[i], tg[i], td[i], m[0]));
    q.rsort();
    base = m[1] ? 0 : N_DEV - K;
    for (int j = 0; j < K; j++) s += q[base + j] * (m[0] ? 3 + j : 1);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; later beats present a random mode that must be ignored.
  task automatic do_txn(input string tag, input logic [1:0] m, input int hold);
    int exp_n;
    logic [OUT_W-1:0] held;
    exp_n = ref_sum(m);
    for (int i = 0; i < N_DEV; i++) begin
      W = 3'(tw[i]); V_GS = 3'(tg[i]); V_DS = 3'(td[i]);
      mode = (i == 0) ? m : 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      chk({tag, "_in_ready_load"}, 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'($urandom_range(0, 1));
    chk({tag, "_sum_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum_in_ready"}, 32'(in_ready), 32'd0);
    tick();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_n"}, 32'(out_n), 32'(exp_n));
    held = out_n;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_stable"}, 32'(out_n), 32'(held));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic fill_same(input int w, input int gs, input int ds);
    for (int i = 0; i < N_DEV; i++) begin tw[i] = w; tg[i] = gs; td[i] = ds; end
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_n", 32'(out_n), 32'd0);
    reset = 1'b1;

    fill_same(7, 7, 7);
    chk("model_t1", 32'(ref_sum(2'b11)), 32'd1008);
    do_txn("t1_id_top", 2'b11, 0);
    do_txn("t2_gm_top", 2'b10, 0);

    for (int i = 0; i < N_DEV; i++) begin tw[i] = i + 1; tg[i] = 2; td[i] = 3; end
    do_txn("t3_id_bot", 2'b01, 0);
    chk("t3_const", 32'(out_n), 32'd3);
    do_txn("t3_id_top", 2'b11, 1);
    chk("t3b_const", 32'(out_n), 32'd15);

    fill_same(0, 0, 0);
    tw[0] = 3; tg[0] = 5; td[0] = 1;
    for (int i = 1; i < N_DEV; i++) begin tw[i] = $urandom_range(0, 7); td[i] = $urandom_range(0, 7); end
    do_txn("t4_id_top", 2'b11, 0);
    chk("t4_const", 32'(out_n), 32'd21);
    do_txn("t4_gm_top", 2'b10, 0);
    chk("t4b_const", 32'(out_n), 32'd2);

    // Abort a transaction partway with reset.
    for (int i = 0; i < 3; i++) begin
      W = 3'd7; V_GS = 3'd7; V_DS = 3'd7; mode = 2'b11; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_out_n", 32'(out_n), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < N_DEV; i++) begin tw[i] = i; tg[i] = 3; td[i] = 0; end
    do_txn("t5_fresh", 2'b01, 0);

    fill_same(5, 6, 2);
    do_txn("t6_hold", 2'b11, 5);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N_DEV; i++) begin
        tw[i] = $urandom_range(0, 7);
        tg[i] = $urandom_range(0, 7);
        td[i] = $urandom_range(0, 7);
      end
      do_txn("rand", 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
